// File: rtl/rcn_fifo_sync_pkg.sv
// Shared defaults and helpers for the RCN single-clock FIFO family.
// Width/depth defaults match those used by the byte-wide async FIFO users.
`timescale 1ns/1ps
package rcn_fifo_sync_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH   = 4;
    localparam int DEF_AFULL_LEVEL  = 12;
    localparam int DEF_AEMPTY_LEVEL = 2;

    // Sticky error flag update: a new event in the same cycle as a clear wins.
    function automatic logic sticky_next(input logic flag, input logic set, input logic clr);
        return set | (flag & ~clr);
    endfunction

endpackage

// File: rtl/rcn_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
// Kept separate so a vendor distributed RAM can be dropped in.
`timescale 1ns/1ps
module rcn_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rcn_fifo_sync.sv
// Parametrised single-clock show-ahead FIFO with fill level, almost flags and
// sticky overflow/underflow errors. Pointers carry one extra wrap bit.
`timescale 1ns/1ps
module rcn_fifo_sync
    import rcn_fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int AFULL_LEVEL  = DEF_AFULL_LEVEL,
    parameter int AEMPTY_LEVEL = DEF_AEMPTY_LEVEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  push,
    output logic                  full,
    output logic                  afull,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  pop,
    output logic                  empty,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   level,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AFULL_L  = AFULL_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_L = AEMPTY_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] head_q;
    logic [ADDR_WIDTH:0] tail_q;
    logic [ADDR_WIDTH:0] level_q;
    logic                overflow_q;
    logic                underflow_q;
    logic                push_ok;
    logic                pop_ok;

    // Flags come only from the registered level, so there is no path from push/pop.
    assign full   = (level_q == DEPTH_L);
    assign empty  = (level_q == '0);
    assign afull  = (level_q >= AFULL_L);
    assign aempty = (level_q <= AEMPTY_L);
    assign level  = level_q;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    rcn_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (head_q[ADDR_WIDTH-1:0]),
        .wdata (din),
        .raddr (tail_q[ADDR_WIDTH-1:0]),
        .rdata (dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (push_ok) begin
                head_q <= head_q + 1'b1;
            end
            if (pop_ok) begin
                tail_q <= tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= sticky_next(overflow_q, push & full, err_clr);
            underflow_q <= sticky_next(underflow_q, pop & empty, err_clr);
        end
    end

endmodule
